mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 8-bit data-memory/SFR bus.
- Requester A is the CPU core; requester B is the loader/debug port.
- Grants one requester per transaction, latches its address/data/direction, and drives the shared bus for the required number of cycles.
- Returns a one-cycle ACK with read data. Bus addresses 1..SFR_LAST are SFR I/O registers (OUT, DIR, IN); all other addresses are RAM.

Parameters:
- RAM_LAT, 2, number of bus cycles a RAM access occupies (legal 1..15).
- SFR_LAST, 8'h03, highest SFR address; addresses 8'h01..SFR_LAST are SFR accesses, including 8'h00 as RAM.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_A  input  1  requester A transaction request.
- ADDR_A  input  8  requester A address.
- WDATA_A  input  8  requester A write data.
- MW_A  input  1  requester A direction: 1 = write, 0 = read.
- ACK_A  output  1  one-cycle completion pulse to requester A.
- REQ_B / ADDR_B / WDATA_B / MW_B / ACK_B  same widths and directions as the A set, for requester B.
- RDATA  output  8  read data; valid in the cycle ACK_A or ACK_B is high.
- BUS_ADDR  output  8  shared bus address.
- BUS_WDATA  output  8  shared bus write data.
- BUS_MW  output  1  shared bus write strobe.
- BUS_RAM_EN  output  1  RAM access enable.
- BUS_SFR  output  1  SFR access in progress.
- BUS_RDATA  input  8  read data returned by RAM/SFR mux.
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (RST high at a clock edge):
  - state becomes IDLE; LAST_GNT becomes B, so A wins the first contention.
  - Every output and bus register becomes 0; the wait counter clears.
- Reset mid-transaction: the transaction aborts with no ACK, and strobes are 0 from the next edge.
- States:
  - IDLE -> ACCESS on any request.
  - ACCESS -> ACCESS while the counter is not expired.
  - ACCESS -> ACKN when the counter expires.
  - ACKN -> IDLE unconditionally.
- Grant, in IDLE at edge t:
  - Only one REQ high: grant that requester.
  - Both high: grant the requester that is not LAST_GNT.
  - Update LAST_GNT to the granted requester.
  - Latch the granted ADDR/WDATA/MW into the BUS_ADDR/BUS_WDATA/BUS_MW registers.
  - Classify the access as SFR (1 <= addr <= SFR_LAST) or RAM.
  - Load the counter with 1 for SFR or RAM_LAT for RAM.
- ACCESS, cycles t+1..t+L:
  - BUS_ADDR and BUS_WDATA hold the latched values.
  - BUS_MW is held at the latched MW.
  - BUS_SFR=1 for SFR accesses; BUS_RAM_EN=1 for RAM accesses.
  - The counter decrements each cycle.
  - On the last ACCESS edge, capture BUS_RDATA into RDATA, for reads and writes alike.
- ACKN, cycle t+L+1:
  - Exactly one ACK, to the granted requester.
  - BUS_MW, BUS_RAM_EN and BUS_SFR are all 0.
  - BUS_ADDR returns to 0.
  - RDATA holds until the next capture.
- Latency is L+1 cycles from the grant edge to ACK. Throughput is one transaction per L+2 cycles.
- Requests are sampled only in IDLE. REQ seen in ACCESS or ACKN is ignored until the next IDLE.
- A requester needing back-to-back transfers keeps REQ high. Under continuous contention, grants alternate A, B, A, B.
- REQ dropped mid-transaction: the transaction completes and ACK still pulses; there is no cancellation.
- Changes on ADDR/WDATA/MW after the grant have no effect, because values are latched.
- The write strobe is never asserted outside ACCESS. Idle bus: address 0, MW 0, all enables 0.
- Counter width is 4 bits. RAM_LAT=1 makes RAM timing identical to SFR timing.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, ACCESS, ACKN;
  - SFR address constants: SFR_OUT=8'h01, SFR_DIR=8'h02, SFR_IN=8'h03;
  - requester ID encoding: A=0, B=1.
- One natural sub-module, rr_arb2: two-way round-robin picker taking REQ_A, REQ_B and LAST_GNT, producing the grant ID and a grant-valid signal.
- FSM, latch and counter stay in mem_bus_arbiter.

Test Plan:
- SFR write: REQ_A=1, ADDR_A=8'h02, WDATA_A=8'h5A, MW_A=1 at t -> t+1: BUS_ADDR=02, BUS_WDATA=5A, BUS_MW=1, BUS_SFR=1, BUS_RAM_EN=0; t+2: ACK_A=1 for one cycle, all strobes 0.
- RAM read (RAM_LAT=2): REQ_B=1, ADDR_B=8'h40, MW_B=0, BUS_RDATA=8'hC3 -> BUS_RAM_EN=1 at t+1 and t+2, BUS_MW=0; t+3: ACK_B=1, RDATA=C3.
- Contention: REQ_A=REQ_B=1 held continuously after reset -> grant order A, B, A, B; ACKs spaced L+2 cycles apart; no ACK pulses simultaneously.
- Boundary decode: addresses 8'h00 and 8'h04 -> RAM path, RAM_LAT access cycles; 8'h01 and 8'h03 -> SFR path, one access cycle.
- Reset mid-access: assert RST in the second RAM cycle -> next cycle all outputs 0, BUSY=0, no ACK; the next request after reset gets requester A priority.
- Dropped request: REQ_A deasserted at t+1 of a RAM write -> access completes with BUS_MW held RAM_LAT cycles, and ACK_A still pulses at t+RAM_LAT+1.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared encodings for the data-memory/SFR bus arbiter: FSM
//               states, SFR register addresses, requester IDs and the
//               SFR/RAM address classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    // Sequencer states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACKN   = 2'd2;

    // SFR I/O register map
    localparam logic [7:0] SFR_OUT = 8'h01;
    localparam logic [7:0] SFR_DIR = 8'h02;
    localparam logic [7:0] SFR_IN  = 8'h03;

    // Width of the access-cycle counter
    localparam int CNT_W = 4;

    // Requester identity: A is the CPU core, B the loader/debug port
    typedef enum logic {
        REQ_ID_A = 1'b0,
        REQ_ID_B = 1'b1
    } req_id_t;

    // Address 0 is RAM; 1..sfr_last are SFRs; everything above is RAM
    function automatic logic is_sfr_addr(input logic [7:0] addr,
                                         input logic [7:0] sfr_last);
        return (addr != 8'h00) && (addr <= sfr_last);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_rr_arb2
// Description : Two-way round-robin picker. A lone request wins outright;
//               on contention the requester that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter_rr_arb2
    import mem_bus_arbiter_pkg::*;
(
    input  logic    req_a,
    input  logic    req_b,
    input  req_id_t last_gnt,
    output req_id_t gnt_id,
    output logic    gnt_valid
);

    // Pick a winner from the current requests and the previous grant
    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_id    = REQ_ID_A;
        if (req_a && req_b) begin
            gnt_id = (last_gnt == REQ_ID_A) ? REQ_ID_B : REQ_ID_A;
        end else if (req_b) begin
            gnt_id = REQ_ID_B;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-requester arbiter and sequencer for the shared 8-bit
//               data-memory/SFR bus. Grants one requester per transaction,
//               latches its request, drives the bus for 1 (SFR) or RAM_LAT
//               (RAM) cycles, then returns a one-cycle ACK with read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int         RAM_LAT  = 2,
    parameter logic [7:0] SFR_LAST = 8'h03
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [7:0] addr_a,
    input  logic [7:0] wdata_a,
    input  logic       mw_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] addr_b,
    input  logic [7:0] wdata_b,
    input  logic       mw_b,
    output logic       ack_b,
    output logic [7:0] rdata,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_mw,
    output logic       bus_ram_en,
    output logic       bus_sfr,
    input  logic [7:0] bus_rdata,
    output logic       busy
);

    localparam logic [CNT_W-1:0] C_RAM_CNT = CNT_W'(RAM_LAT);
    localparam logic [CNT_W-1:0] C_SFR_CNT = CNT_W'(1);

    logic [1:0]       r_state;
    req_id_t          r_last_gnt;
    req_id_t          r_gnt_id;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_addr;
    logic [7:0]       r_wdata;
    logic             r_mw;
    logic             r_sfr;
    logic             r_ram_en;
    logic             r_ack_a;
    logic             r_ack_b;
    logic [7:0]       r_rdata;

    req_id_t          w_gnt_id;
    logic             w_gnt_valid;
    logic [7:0]       w_sel_addr;
    logic [7:0]       w_sel_wdata;
    logic             w_sel_mw;
    logic             w_sel_sfr;

    mem_bus_arbiter_rr_arb2 u_rr_arb2 (
        .req_a     (req_a),
        .req_b     (req_b),
        .last_gnt  (r_last_gnt),
        .gnt_id    (w_gnt_id),
        .gnt_valid (w_gnt_valid)
    );

    // Route the winning requester's address/data/direction and classify it
    always_comb begin
        w_sel_addr  = (w_gnt_id == REQ_ID_B) ? addr_b  : addr_a;
        w_sel_wdata = (w_gnt_id == REQ_ID_B) ? wdata_b : wdata_a;
        w_sel_mw    = (w_gnt_id == REQ_ID_B) ? mw_b    : mw_a;
        w_sel_sfr   = is_sfr_addr(w_sel_addr, SFR_LAST);
    end

    // Sequencer: grant and latch in IDLE, count out ACCESS, pulse ACK in ACKN.
    // Bus strobes are cleared on the same edge that enters ACKN so they are
    // never visible outside ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= REQ_ID_B;
            r_gnt_id   <= REQ_ID_A;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mw       <= 1'b0;
            r_sfr      <= 1'b0;
            r_ram_en   <= 1'b0;
            r_ack_a    <= 1'b0;
            r_ack_b    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_state    <= ST_ACCESS;
                        r_last_gnt <= w_gnt_id;
                        r_gnt_id   <= w_gnt_id;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_mw       <= w_sel_mw;
                        r_sfr      <= w_sel_sfr;
                        r_ram_en   <= ~w_sel_sfr;
                        r_cnt      <= w_sel_sfr ? C_SFR_CNT : C_RAM_CNT;
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state  <= ST_ACKN;
                        r_rdata  <= bus_rdata;
                        r_ack_a  <= (r_gnt_id == REQ_ID_A);
                        r_ack_b  <= (r_gnt_id == REQ_ID_B);
                        r_addr   <= '0;
                        r_wdata  <= '0;
                        r_mw     <= 1'b0;
                        r_sfr    <= 1'b0;
                        r_ram_en <= 1'b0;
                    end
                end
                ST_ACKN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the ports from the registered state
    always_comb begin
        ack_a      = r_ack_a;
        ack_b      = r_ack_b;
        rdata      = r_rdata;
        bus_addr   = r_addr;
        bus_wdata  = r_wdata;
        bus_mw     = r_mw;
        bus_ram_en = r_ram_en;
        bus_sfr    = r_sfr;
        busy       = (r_state != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Directed steps drive
//               requests; expected ACK identity and read data are queued when
//               a request is driven and popped when the DUT pulses an ACK.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int RAM_LAT = 2;

    logic       clk;
    logic       rst;
    logic       req_a, req_b;
    logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
    logic       mw_a, mw_b;
    logic       ack_a, ack_b;
    logic [7:0] rdata, bus_addr, bus_wdata, bus_rdata;
    logic       bus_mw, bus_ram_en, bus_sfr, busy;

    typedef struct {
        logic       id;
        logic [7:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    mem_bus_arbiter #(
        .RAM_LAT  (RAM_LAT),
        .SFR_LAST (8'h03)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .addr_a     (addr_a),
        .wdata_a    (wdata_a),
        .mw_a       (mw_a),
        .ack_a      (ack_a),
        .req_b      (req_b),
        .addr_b     (addr_b),
        .wdata_b    (wdata_b),
        .mw_b       (mw_b),
        .ack_b      (ack_b),
        .rdata      (rdata),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_mw     (bus_mw),
        .bus_ram_en (bus_ram_en),
        .bus_sfr    (bus_sfr),
        .bus_rdata  (bus_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_ack(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!(ack_a || ack_b) && cnt < 20);
    endtask

    // Scoreboard: every ACK must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (ack_a || ack_b) begin
            chk("sb_one_ack", {31'd0, ack_a & ack_b}, 32'd0);
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ack_id", {31'd0, ack_b}, {31'd0, e.id});
                chk("sb_rdata", {24'd0, rdata}, {24'd0, e.rd});
            end
        end
    end

    // One complete transaction; the request drops (and inputs scramble) right
    // after the grant to prove the request is latched and not cancellable.
    task automatic run_txn(input logic is_b, input logic [7:0] addr, input logic [7:0] wd,
                           input logic mw, input logic [7:0] rd);
        logic sfr;
        int   lat;
        sfr = (addr >= 8'h01) && (addr <= 8'h03);
        lat = sfr ? 1 : RAM_LAT;
        bus_rdata = rd;
        if (is_b) begin
            req_b = 1'b1; addr_b = addr; wdata_b = wd; mw_b = mw;
        end else begin
            req_a = 1'b1; addr_a = addr; wdata_a = wd; mw_a = mw;
        end
        sb.push_back('{is_b, rd});
        cyc();
        req_a = 1'b0; req_b = 1'b0;
        addr_a = ~addr; addr_b = ~addr; wdata_a = ~wd; wdata_b = ~wd; mw_a = ~mw; mw_b = ~mw;
        for (int i = 0; i < lat; i++) begin
            chk("acc_addr",   {24'd0, bus_addr},  {24'd0, addr});
            chk("acc_wdata",  {24'd0, bus_wdata}, {24'd0, wd});
            chk("acc_mw",     {31'd0, bus_mw},    {31'd0, mw});
            chk("acc_sfr",    {31'd0, bus_sfr},   {31'd0, sfr});
            chk("acc_ram_en", {31'd0, bus_ram_en},{31'd0, ~sfr});
            chk("acc_noack",  {30'd0, ack_b, ack_a}, 32'd0);
            chk("acc_busy",   {31'd0, busy}, 32'd1);
            cyc();
        end
        chk("ackn_ack",     {30'd0, ack_b, ack_a}, is_b ? 32'd2 : 32'd1);
        chk("ackn_strobes", {29'd0, bus_mw, bus_ram_en, bus_sfr}, 32'd0);
        chk("ackn_addr",    {24'd0, bus_addr}, 32'd0);
        chk("ackn_rdata",   {24'd0, rdata}, {24'd0, rd});
        cyc();
        chk("idle_busy",    {31'd0, busy}, 32'd0);
        chk("idle_noack",   {30'd0, ack_b, ack_a}, 32'd0);
        chk("idle_rdata",   {24'd0, rdata}, {24'd0, rd});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        addr_a = 8'h00; addr_b = 8'h00; wdata_a = 8'h00; wdata_b = 8'h00;
        mw_a = 1'b0; mw_b = 1'b0;
        bus_rdata = 8'hEE;
        cyc(); cyc();
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_bus",   {8'd0, bus_addr, bus_wdata, 5'd0, bus_mw, bus_ram_en, bus_sfr}, 32'd0);
        chk("rst_ack",   {30'd0, ack_b, ack_a}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        rst = 1'b0;
        cyc();

        // Continuous contention straight out of reset: A, B, A, B
        bus_rdata = 8'h77;
        req_a = 1'b1; addr_a = 8'h10; wdata_a = 8'h11; mw_a = 1'b1;
        req_b = 1'b1; addr_b = 8'h20; wdata_b = 8'h22; mw_b = 1'b0;
        for (int k = 0; k < 4; k++) sb.push_back('{k[0], 8'h77});
        for (int k = 0; k < 4; k++) begin
            wait_ack(cnt);
            chk("cont_gap",   cnt, (k == 0) ? RAM_LAT + 1 : RAM_LAT + 2);
            chk("cont_order", {30'd0, ack_b, ack_a}, k[0] ? 32'd2 : 32'd1);
            if (k == 3) begin
                req_a = 1'b0; req_b = 1'b0;
            end
        end
        cyc(); cyc();
        chk("cont_idle", {31'd0, busy}, 32'd0);

        // Directed transactions, including the decode boundaries
        run_txn(1'b0, 8'h02, 8'h5A, 1'b1, 8'h13);   // SFR write
        run_txn(1'b1, 8'h40, 8'h00, 1'b0, 8'hC3);   // RAM read
        run_txn(1'b0, 8'h00, 8'hA1, 1'b0, 8'h6D);   // address 0 is RAM
        run_txn(1'b1, 8'h04, 8'hB2, 1'b1, 8'h2E);   // just above SFRs
        run_txn(1'b1, 8'h01, 8'hC4, 1'b0, 8'h81);   // lowest SFR
        run_txn(1'b0, 8'h03, 8'hD5, 1'b1, 8'h9F);   // highest SFR
        run_txn(1'b0, 8'h80, 8'hE6, 1'b1, 8'h55);   // RAM write, request dropped

        // Reset in the second RAM cycle aborts without an ACK
        bus_rdata = 8'h3C;
        req_a = 1'b1; addr_a = 8'h50; wdata_a = 8'h99; mw_a = 1'b1;
        cyc();
        req_a = 1'b0;
        chk("abort_ram_en", {31'd0, bus_ram_en}, 32'd1);
        cyc();
        chk("abort_mw", {31'd0, bus_mw}, 32'd1);
        rst = 1'b1;
        cyc();
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_bus",   {8'd0, bus_addr, bus_wdata, 5'd0, bus_mw, bus_ram_en, bus_sfr}, 32'd0);
        chk("abort_ack",   {30'd0, ack_b, ack_a}, 32'd0);
        chk("abort_rdata", {24'd0, rdata}, 32'd0);
        rst = 1'b0;
        cyc();
        chk("abort_noack", {30'd0, ack_b, ack_a}, 32'd0);

        // After reset A wins contention again, even though A was granted last
        bus_rdata = 8'h42;
        req_a = 1'b1; addr_a = 8'h60; wdata_a = 8'h01; mw_a = 1'b0;
        req_b = 1'b1; addr_b = 8'h61; wdata_b = 8'h02; mw_b = 1'b0;
        sb.push_back('{1'b0, 8'h42});
        cyc();
        req_a = 1'b0; req_b = 1'b0;
        chk("prio_addr", {24'd0, bus_addr}, 32'h60);
        wait_ack(cnt);
        chk("prio_gap", cnt, RAM_LAT);
        chk("prio_ack", {30'd0, ack_b, ack_a}, 32'd1);
        cyc(); cyc();
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
